seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/ripple_subtractor.sv | 23 ++
 rtl/seq_divider.sv | 117 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_subtractor.sv
// N-bit ripple-borrow subtractor: diff = a - b, bout set when a < b.
module ripple_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] bw;

  assign bw[0] = 1'b0;

  // One full-subtractor cell per bit, borrow rippling upward.
  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign bout = bw[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per RUN cycle.
// Results and flags are registered on the DONE->IDLE edge together with
// the one-cycle done pulse, so they stay stable until the next division.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_nx;

  logic [WIDTH:0]   a;       // partial remainder, one guard bit
  logic [WIDTH-1:0] q;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] m;       // latched divisor
  logic [CW-1:0]    count;   // iterations left
  logic             dz;      // latched divide-by-zero, published with done

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   d;
  logic             borrow;

  // {A,Q} shifted left one bit as a pair.
  assign a_sh = (a << 1) | (WIDTH+1)'(q[WIDTH-1]);
  assign q_sh = q << 1;

  ripple_subtractor #(.N(WIDTH + 1)) u_sub (
    .a    (a_sh),
    .b    ({1'b0, m}),
    .diff (d),
    .bout (borrow)
  );

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: zero divisor skips straight to DONE; RUN lasts WIDTH cycles.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (divisor == '0) ? DONE : RUN;
      RUN:     if (count == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Iteration datapath and registered results.
  always_ff @(posedge clock) begin
    if (reset) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Preload the saturated result so DONE publishes it uniformly.
              m     <= '0;
              q     <= '1;
              a     <= {1'b0, dividend};
              count <= '0;
              dz    <= 1'b1;
            end else begin
              m           <= divisor;
              q           <= dividend;
              a           <= '0;
              count       <= CW'(WIDTH);
              dz          <= 1'b0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          // Restoring step: keep the difference only if it did not borrow.
          a     <= borrow ? a_sh : d;
          q     <= q_sh | WIDTH'(!borrow);
          count <= count - CW'(1);
        end
        DONE: begin
          quotient    <= q;
          remainder   <= a[WIDTH-1:0];
          div_by_zero <= dz;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
